uart_frame_decoder: RTL



---
 rtl/game_pkg.sv | 15 +
 rtl/link_watchdog.sv | 28 ++
 rtl/uart_frame_decoder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game-state UART framing constants and the receive-side frame state type.
package game_pkg;

  localparam logic [7:0] UART_SYNC_BYTE = 8'hA5;
  localparam int         UART_FRAME_LEN = 7;

  typedef enum logic [2:0] {
    HUNT,
    PAYLOAD,
    CHECK,
    APPLY,
    REJECT
  } uart_frame_state;

endpackage

// File: rtl/link_watchdog.sv
// Saturating up-counter with synchronous clear; expired is high while the count sits at LIMIT.
module link_watchdog #(
  parameter int unsigned LIMIT = 65_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expired
);

  localparam int unsigned  W       = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (count != LIMIT_W) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT_W);

endmodule

// File: rtl/uart_frame_decoder.sv
// Pops bytes from the UART RX FIFO, hunts for sync, checks the 7-byte game-state frame and
// applies good frames atomically to the remote-state outputs; tracks link health.
module uart_frame_decoder
  import game_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = UART_SYNC_BYTE,
  parameter int unsigned GAP_CYCLES   = 65_000,
  parameter int unsigned LINK_TIMEOUT = 65_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      read_data,
  input  logic            rx_empty,
  output logic            rd_uart,
  output logic [7:0]      current_x_1,
  output logic [7:0]      current_y_1,
  output logic [7:0]      current_x_2,
  output logic [7:0]      current_y_2,
  output logic            player1_collision,
  output logic            player2_collision,
  output logic [1:0]      selected_player,
  output logic            frame_valid,
  output logic            link_ok,
  output logic [7:0]      err_cnt,
  output uart_frame_state fsm_state
);

  localparam logic [2:0] LAST_PAYLOAD = 3'(UART_FRAME_LEN - 2);

  uart_frame_state state;
  logic [2:0]      idx;
  logic [7:0]      acc;
  logic [39:0]     payload;
  logic            in_frame;
  logic            pop;
  logic            gap_expired;
  logic            wd_expired;

  // FIFO handshake: read_data is valid whenever rx_empty=0. A byte is taken (pop) on the
  // edge that raises rd_uart; rd_uart then stays high for exactly one cycle so the FIFO
  // advances its head, and no new byte is taken in that cycle.
  assign in_frame = (state == PAYLOAD) || (state == CHECK);
  assign pop      = !rx_empty && !rd_uart && ((state == HUNT) || in_frame);
  assign fsm_state = state;

  link_watchdog #(.LIMIT(GAP_CYCLES)) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (pop || !in_frame),
    .expired (gap_expired)
  );

  link_watchdog #(.LIMIT(LINK_TIMEOUT)) u_link_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == APPLY),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= HUNT;
      idx               <= '0;
      acc               <= '0;
      payload           <= '0;
      rd_uart           <= 1'b0;
      current_x_1       <= '0;
      current_y_1       <= '0;
      current_x_2       <= '0;
      current_y_2       <= '0;
      player1_collision <= 1'b0;
      player2_collision <= 1'b0;
      selected_player   <= '0;
      frame_valid       <= 1'b0;
      link_ok           <= 1'b0;
      err_cnt           <= '0;
    end else begin
      rd_uart     <= pop;
      frame_valid <= 1'b0;
      // A frame landing in the same cycle the watchdog expires keeps the link up.
      if (state == APPLY) begin
        link_ok <= 1'b1;
      end else if (wd_expired) begin
        link_ok <= 1'b0;
      end

      case (state)
        HUNT: begin
          if (pop && (read_data == SYNC_BYTE)) begin
            state <= PAYLOAD;
            idx   <= 3'd1;
            acc   <= '0;
          end
        end
        PAYLOAD: begin
          if (pop) begin
            payload <= {payload[31:0], read_data};
            acc     <= acc ^ read_data;
            if (idx == LAST_PAYLOAD) begin
              state <= CHECK;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (gap_expired) begin
            state <= REJECT;
          end
        end
        CHECK: begin
          if (pop) begin
            state <= ((read_data == acc) && (payload[7:4] == 4'h0)) ? APPLY : REJECT;
          end else if (gap_expired) begin
            state <= REJECT;
          end
        end
        APPLY: begin
          current_x_1       <= payload[39:32];
          current_y_1       <= payload[31:24];
          current_x_2       <= payload[23:16];
          current_y_2       <= payload[15:8];
          selected_player   <= payload[3:2];
          player2_collision <= payload[1];
          player1_collision <= payload[0];
          frame_valid       <= 1'b1;
          state             <= HUNT;
        end
        REJECT: begin
          if (err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 1'b1;
          end
          state <= HUNT;
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule
